// File: rtl/fetch_queue_if.sv
// Signal bundle between the fetch queue, instruction memory, the MEM-stage
// redirect source and the decode stage.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          redirect;
    logic [63:0]   redirect_pc;
    logic          imem_req;
    logic [63:0]   imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [63:0]   out_pc;
    logic          out_ready;
    logic [CW-1:0] out_count;

    // Fetch-queue side
    modport master (
        input  redirect, redirect_pc, imem_ack, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_instr, out_pc, out_count
    );

    // Memory / pipeline side
    modport slave (
        output redirect, redirect_pc, imem_ack, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: keeps at most one imem request outstanding and
// buffers returned instructions in fetch order until decode takes them.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned PCW = 64;
    localparam int unsigned IW  = 32;

    // Bit 0 doubles as the imem request flag
    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_WAIT    = 2'b01;
    localparam logic [1:0] S_DISCARD = 2'b11;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic [IW-1:0]  instr;
    } entry_t;

    logic [1:0]     state_q, state_d;
    logic           started_q;
    logic [PCW-1:0] fetch_pc_q, fetch_pc_d;
    logic [PCW-1:0] addr_q, addr_d;
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           valid_q;
    entry_t         mem_q [DEPTH];

    logic           push, pop, flush;
    logic [CW-1:0]  count_pp;
    logic [PCW-1:0] pc_plus4;

    // Request FSM: issue, back-to-back refetch, redirect flush and discard
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        push       = 1'b0;
        flush      = 1'b0;
        pop        = valid_q && bus.out_ready;
        pc_plus4   = fetch_pc_q + PCW'(4);
        count_pp   = count_q + CW'(1) - CW'(pop);

        case (state_q)
            S_IDLE: begin
                if (bus.redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = bus.redirect_pc;
                end else if (started_q && (count_q < CW'(DEPTH))) begin
                    state_d = S_WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            S_WAIT: begin
                if (bus.redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = bus.redirect_pc;
                    state_d    = bus.imem_ack ? S_IDLE : S_DISCARD;
                end else if (bus.imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = pc_plus4;
                    if (count_pp < CW'(DEPTH)) begin
                        addr_d = pc_plus4;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DISCARD: begin
                if (bus.redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = bus.redirect_pc;
                end
                if (bus.imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Queue bookkeeping; a flush overrides any same-cycle push or pop
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            wptr_d  = wptr_q + AW'(push);
            rptr_d  = rptr_q + AW'(pop);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            started_q  <= 1'b0;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            started_q  <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            valid_q    <= (count_d != '0);
        end
    end

    // Entry storage; cleared on reset so the head reads as zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[AW'(i)] <= '0;
            end
        end else if (push) begin
            mem_q[wptr_q] <= '{pc: fetch_pc_q, instr: bus.imem_rdata};
        end
    end

    assign bus.imem_req  = state_q[0];
    assign bus.imem_addr = addr_q;
    assign bus.out_valid = valid_q;
    assign bus.out_count = count_q;
    assign bus.out_pc    = mem_q[rptr_q].pc;
    assign bus.out_instr = mem_q[rptr_q].instr;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, all checked
// against a transaction-level queue model of the fetch rules.
module tb_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'd0;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_fpc;
    logic [63:0] m_addr;
    bit          m_pend;
    bit          m_disc;
    bit          m_started;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_fpc     = RESET_PC;
        m_addr    = RESET_PC;
        m_pend    = 1'b0;
        m_disc    = 1'b0;
        m_started = 1'b0;
    endfunction

    // One clock edge of the fetch rules, expressed on a plain queue
    function automatic void model_update(input logic rd, input logic [63:0] rpc,
                                         input logic ack, input logic rdy,
                                         input logic [31:0] data);
        int   sz0;
        ent_t e;
        sz0 = mq.size();
        if (rd) begin
            mq.delete();
            m_fpc = rpc;
            if (m_pend) begin
                if (ack) begin
                    m_pend = 1'b0;
                    m_disc = 1'b0;
                end else begin
                    m_disc = 1'b1;
                end
            end
        end else begin
            if (sz0 != 0 && rdy) void'(mq.pop_front());
            if (m_pend) begin
                if (ack) begin
                    m_pend = 1'b0;
                    if (m_disc) begin
                        m_disc = 1'b0;
                    end else begin
                        e.pc    = m_fpc;
                        e.instr = data;
                        mq.push_back(e);
                        m_fpc = m_fpc + 64'd4;
                        if (mq.size() < DEPTH) begin
                            m_pend = 1'b1;
                            m_addr = m_fpc;
                        end
                    end
                end
            end else if (m_started && sz0 < DEPTH) begin
                m_pend = 1'b1;
                m_addr = m_fpc;
            end
        end
        m_started = 1'b1;
    endfunction

    task automatic check_model();
        chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
        chk("out_count", 64'(bus.out_count), 64'(mq.size()));
        if (mq.size() != 0) begin
            chk("out_pc", bus.out_pc, mq[0].pc);
            chk("out_instr", 64'(bus.out_instr), 64'(mq[0].instr));
        end
        chk("imem_req", 64'(bus.imem_req), 64'(m_pend));
        if (m_pend) chk("imem_addr", bus.imem_addr, m_addr);
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic step(input logic rd, input logic [63:0] rpc, input logic ack, input logic rdy);
        logic [31:0] data;
        data            = $urandom;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.imem_ack    = ack;
        bus.imem_rdata  = data;
        bus.out_ready   = rdy;
        check_model();
        model_update(rd, rpc, ack, rdy, data);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   64'(bus.imem_req), 64'd0);
        chk({tag, "_addr"},  bus.imem_addr, RESET_PC);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_count"}, 64'(bus.out_count), 64'd0);
        chk({tag, "_instr"}, 64'(bus.out_instr), 64'd0);
        chk({tag, "_pc"},    bus.out_pc, 64'd0);
    endtask

    // Asynchronous reset in the middle of the low clock phase
    task automatic do_reset(input string tag);
        #2 reset = 1'b0;
        #1 chk_reset(tag);
        bus.redirect  = 1'b0;
        bus.imem_ack  = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [63:0] wrap_exp [2];
        bit          seen;
        int          n;

        bus.redirect    = 1'b0;
        bus.redirect_pc = 64'd0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'd0;
        bus.out_ready   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset("por");
        reset = 1'b1;

        // Streaming: one instruction per cycle after warm-up
        for (int i = 0; i < 24; i++) begin
            if (i == 1) chk("first_edge_idle", 64'(bus.imem_req), 64'd0);
            if (i == 2) begin
                chk("first_req", 64'(bus.imem_req), 64'd1);
                chk("first_addr", bus.imem_addr, RESET_PC);
            end
            if (i >= 3) begin
                chk("stream_valid", 64'(bus.out_valid), 64'd1);
                chk("stream_pc", bus.out_pc, RESET_PC + 64'(4 * (i - 3)));
            end
            step(1'b0, 64'd0, m_pend, 1'b1);
        end

        // Stall: queue fills, fetch stops, drain resumes at 16
        do_reset("rst_stall");
        for (int i = 0; i < 12; i++) step(1'b0, 64'd0, m_pend, 1'b0);
        chk("stall_count", 64'(bus.out_count), 64'd4);
        chk("stall_req", 64'(bus.imem_req), 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk("drain_pc", bus.out_pc, 64'(4 * k));
            step(1'b0, 64'd0, 1'b0, 1'b1);
        end
        chk("resume_req", 64'(bus.imem_req), 64'd1);
        chk("resume_addr", bus.imem_addr, 64'd16);

        // Redirect while waiting; ack three cycles later is dropped
        step(1'b1, 64'h100, 1'b0, 1'b1);
        chk("discard_addr0", bus.imem_addr, 64'd16);
        step(1'b0, 64'd0, 1'b0, 1'b1);
        chk("discard_addr1", bus.imem_addr, 64'd16);
        step(1'b0, 64'd0, 1'b0, 1'b1);
        chk("discard_addr2", bus.imem_addr, 64'd16);
        chk("discard_req", 64'(bus.imem_req), 64'd1);
        step(1'b0, 64'd0, 1'b1, 1'b1);
        chk("discard_drop", 64'(bus.out_valid), 64'd0);
        step(1'b0, 64'd0, 1'b0, 1'b1);
        chk("refetch_req", 64'(bus.imem_req), 64'd1);
        chk("refetch_addr", bus.imem_addr, 64'h100);

        // Redirect coincident with ack and pop
        step(1'b0, 64'd0, 1'b1, 1'b1);
        chk("pre_redir_pc", bus.out_pc, 64'h100);
        step(1'b1, 64'h200, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!seen && bus.out_valid) begin
                chk("redir_first_pc", bus.out_pc, 64'h200);
                seen = 1'b1;
            end
            step(1'b0, 64'd0, m_pend, 1'b1);
        end
        chk("redir_seen", 64'(seen), 64'd1);

        // Fetch address wraps past the top of the address space
        wrap_exp[0] = 64'hFFFF_FFFF_FFFF_FFFC;
        wrap_exp[1] = 64'h0;
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, m_pend, 1'b1);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (n < 2 && bus.out_valid) begin
                chk("wrap_pc", bus.out_pc, wrap_exp[n]);
                n++;
            end
            step(1'b0, 64'd0, m_pend, 1'b1);
        end
        chk("wrap_seen", 64'(n), 64'd2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0),
                 64'({$urandom(), $urandom()}) & ~64'd3,
                 m_pend && ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 3) != 0));
        end

        // Reset with two entries held and a request outstanding
        step(1'b1, 64'h3000, m_pend, 1'b0);
        for (int i = 0; i < 30 && !(mq.size() == 2 && m_pend); i++) begin
            step(1'b0, 64'd0, m_pend, 1'b0);
        end
        chk("pre_reset_count", 64'(bus.out_count), 64'd2);
        chk("pre_reset_req", 64'(bus.imem_req), 64'd1);
        do_reset("rst_wait");
        step(1'b0, 64'd0, 1'b1, 1'b1);
        step(1'b0, 64'd0, 1'b0, 1'b1);
        chk("post_reset_req", 64'(bus.imem_req), 64'd1);
        chk("post_reset_addr", bus.imem_addr, RESET_PC);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!seen && bus.out_valid) begin
                chk("post_reset_pc", bus.out_pc, RESET_PC);
                seen = 1'b1;
            end
            step(1'b0, 64'd0, m_pend, 1'b0);
        end
        chk("post_reset_seen", 64'(seen), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of 2, >=2).
REQ-002 SHALL have parameter RESET_PC, default 64'd0, fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port redirect  input  1  branch taken from MEM stage; flush and refetch.
REQ-006 SHALL have port redirect_pc  input  64  new fetch address when redirect=1.
REQ-007 SHALL have port imem_req  output  1  instruction-memory request outstanding.
REQ-008 SHALL have port imem_addr  output  64  request address.
REQ-009 SHALL have port imem_ack  input  1  response valid, one cycle per request.
REQ-010 SHALL have port imem_rdata  input  32  instruction, valid with imem_ack.
REQ-011 SHALL have port out_valid  output  1  head entry valid toward IF/ID register.
REQ-012 SHALL have port out_instr  output  32  head instruction.
REQ-013 SHALL have port out_pc  output  64  head instruction address.
REQ-014 SHALL have port out_ready  input  1  decode accepts head (0 = stall).
REQ-015 SHALL have port out_count  output  $clog2(DEPTH)+1  entries held.

Function
REQ-016 SHALL implement states IDLE, WAIT (request outstanding), DISCARD (outstanding request whose data is dropped).
REQ-017 SHALL drive imem_req=1 exactly in WAIT and DISCARD; at most one request outstanding.
REQ-018 SHALL hold imem_addr stable from request until the cycle imem_ack is seen, including in DISCARD.
REQ-019 IDLE: if out_count<DEPTH and redirect=0, next state WAIT with imem_addr=fetch_pc; else stay IDLE.
REQ-020 WAIT, imem_ack=1, redirect=0: push {fetch_pc, imem_rdata}; fetch_pc<=fetch_pc+4; if count after push/pop <DEPTH stay WAIT with imem_addr=fetch_pc+4 (back-to-back), else IDLE.
REQ-021 WAIT, imem_ack=0: hold state and address.
REQ-022 Redirect (highest priority): queue flushed (count 0, out_valid 0 next cycle), fetch_pc<=redirect_pc; any simultaneous pop and push ignored.
REQ-023 Redirect in WAIT without imem_ack -> DISCARD; with imem_ack -> IDLE, data dropped.
REQ-024 DISCARD: on imem_ack drop data, go IDLE; redirect in DISCARD updates fetch_pc, stays DISCARD until ack.
REQ-025 out_valid=(count!=0); out_instr/out_pc from head entry; pop when out_valid&out_ready.
REQ-026 Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-027 Latency: imem_ack in cycle N -> entry visible on out_* in cycle N+1 when queue was empty.
REQ-028 A request SHALL never be issued that could overflow the queue (space reserved at issue).
REQ-029 fetch_pc+4 SHALL wrap modulo 2^64; read/write pointers wrap modulo DEPTH.
REQ-030 out_pc order SHALL equal fetch order; no entry from before a redirect SHALL appear after it.

Reset
REQ-031 reset=0 SHALL immediately force: state IDLE, fetch_pc=RESET_PC, pointers 0, out_count=0, out_valid=0, imem_req=0, imem_addr=RESET_PC, out_instr=0, out_pc=0.
REQ-032 Reset mid-request SHALL abandon the request; first request after release SHALL be at RESET_PC.
REQ-033 First imem_req SHALL assert on the second rising edge after reset deasserts (one IDLE cycle).

Verification
REQ-034 Streaming: ack 1 cycle after each req, out_ready=1 -> out_pc 0,4,8,12,... with matching instructions, no gaps after warm-up.
REQ-035 Stall: out_ready=0 -> queue fills with pc 0,4,8,12, out_count=4, imem_req=0; out_ready=1 -> drains in order, fetch resumes at 16.
REQ-036 Redirect to 0x100 in WAIT, ack 3 cycles later -> imem_addr unchanged until ack, data dropped, out_valid=0, next imem_addr=0x100.
REQ-037 Redirect to 0x200 coincident with imem_ack and pop -> no old-stream entry emitted; first out_pc=0x200.
REQ-038 Redirect to 0xFFFF_FFFF_FFFF_FFFC -> entries at that address then 0x0.
REQ-039 reset=0 asserted in WAIT with 2 entries -> all outputs at reset values same cycle; after release req at RESET_PC, stale ack ignored.
